// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash arbiter and the requesters that
// form flash byte addresses.
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      RELEASE
   } arb_state_t;

   localparam int                      FLASH_ADDR_W    = 24;
   localparam logic [FLASH_ADDR_W-1:0] FLASH_GAME_BASE = 24'h400000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo NREQ.
module rr_pick #(
   parameter  int NREQ  = 3,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // NOTE: every output and temporary gets a default before the scan, so no
   // path through this block can leave a value held and infer a latch.
   always_comb begin
      logic [IDX_W-1:0] cand;
      idx  = '0;
      any  = 1'b0;
      cand = last;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + 1'b1;
         if (!any && req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter with burst locking in front of the single flashmem SPI
// byte reader; owner switches always pass through a one-cycle RELEASE.
module flash_arbiter
   import flash_arb_pkg::*;
#(
   parameter  int NREQ      = 3,
   parameter  int MAX_BURST = 1024,
   parameter  int ADDR_W    = FLASH_ADDR_W,
   localparam int IDX_W     = $clog2(NREQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   output logic [NREQ-1:0]          req_ready,
   output logic [7:0]               rdata,
   output logic [IDX_W-1:0]         grant,
   output logic                     busy,
   output logic                     mem_valid,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ready,
   input  logic [7:0]               mem_rdata
);

   localparam int              CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t       state, state_n;
   logic [IDX_W-1:0] grant_n, last, last_n, pick_idx;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_n;
   logic             ready_q;
   logic             pick_any, owner_valid, others_pending;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (req_valid),
      .last (last),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign rdata          = mem_rdata;
   assign owner_valid    = req_valid[grant];
   assign others_pending = |(req_valid & ~(NREQ'(1) << grant));

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      last_n      = last;
      burst_cnt_n = burst_cnt;
      mem_valid   = 1'b0;
      mem_addr    = '0;
      req_ready   = '0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n     = GRANTED;
               grant_n     = pick_idx;
               burst_cnt_n = '0;
            end
         end
         GRANTED: begin
            mem_valid        = owner_valid;
            mem_addr         = req_addr[int'(grant)*ADDR_W +: ADDR_W];
            req_ready[grant] = mem_ready;
            if (mem_ready && burst_cnt != BURST_MAX)
               burst_cnt_n = burst_cnt + 1'b1;
            // Owner done or aborted; otherwise yield at the burst limit only
            // on a byte boundary so flashmem never sees an address swap.
            if (!owner_valid && !mem_ready)
               state_n = RELEASE;
            else if (mem_ready && burst_cnt == BURST_LAST && others_pending)
               state_n = RELEASE;
            else if (burst_cnt == BURST_MAX && others_pending && (ready_q || !owner_valid))
               state_n = RELEASE;
         end
         RELEASE: begin
            last_n  = grant;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         last      <= IDX_W'(NREQ - 1);
         burst_cnt <= '0;
         busy      <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         last      <= last_n;
         burst_cnt <= burst_cnt_n;
         busy      <= (state_n != IDLE);
         ready_q   <= (state == GRANTED) && mem_ready;
      end
   end

endmodule
